// File: rtl/instr_fetch_pkg.sv
// Shared constants, state encoding and helpers for the instruction fetch stage.
// An instruction is four consecutive 32-bit program words.
package instr_fetch_pkg;

   localparam int          WORDS_PER_INSTR = 4;
   localparam logic [31:0] PC_STEP         = 32'd4;

   localparam int OPCODE = 0;
   localparam int ARG1   = 1;
   localparam int ARG2   = 2;
   localparam int DEST   = 3;

   typedef enum logic [1:0] {
      ISSUE = 2'd0,
      LAST  = 2'd1,
      FULL  = 2'd2
   } fetch_state_t;

   // Instructions always start on a 4-word boundary.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_word_buf.sv
// Staging registers holding the words of one instruction while it is being fetched.
// A clear wipes every word; otherwise one indexed word may be written per cycle.
module instr_word_buf
   import instr_fetch_pkg::*;
#(
   parameter int unsigned UUID = 0,
   parameter string       NAME = ""
) (
   input  logic                             clk,
   input  logic                             clear,
   input  logic                             wr_en,
   input  logic [1:0]                       wr_idx,
   input  logic [31:0]                      wr_data,
   output logic [WORDS_PER_INSTR-1:0][31:0] words
);

   always_ff @(posedge clk) begin
      if (clear) begin
         words <= '0;
      end else if (wr_en) begin
         words[wr_idx] <= wr_data;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: reads four program words per instruction and presents the
// assembled instruction downstream through a valid/ready handshake.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int unsigned UUID     = 0,
   parameter string       NAME     = "",
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] Mem_addr,
   output logic        Mem_rd,
   input  logic [31:0] Mem_data,
   output logic [31:0] Op_code,
   output logic [31:0] Arg_1,
   output logic [31:0] Arg_2,
   output logic [31:0] Dest,
   output logic [31:0] Pc,
   output logic        Instr_valid,
   input  logic        Instr_ready,
   input  logic        Jump,
   input  logic [31:0] Jump_addr
);

   fetch_state_t state, state_nxt;
   logic [1:0]   idx, idx_nxt;
   logic [31:0]  fetch_pc, fetch_pc_nxt;

   logic         slot_free;
   logic         transfer;
   logic         handshake;
   logic         buf_we;
   logic [1:0]   buf_idx;
   logic [WORDS_PER_INSTR-1:0][31:0] buf_words;

   assign slot_free = !Instr_valid || Instr_ready;
   assign handshake = Instr_valid && Instr_ready;
   assign Mem_addr  = fetch_pc + {30'b0, idx};

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ISSUE;
         idx      <= 2'd0;
         fetch_pc <= align_word(RESET_PC);
      end else begin
         state    <= state_nxt;
         idx      <= idx_nxt;
         fetch_pc <= fetch_pc_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      idx_nxt      = idx;
      fetch_pc_nxt = fetch_pc;
      if (Jump) begin
         state_nxt    = ISSUE;
         idx_nxt      = 2'd0;
         fetch_pc_nxt = align_word(Jump_addr);
      end else begin
         case (state)
            ISSUE: begin
               idx_nxt = idx + 2'd1;
               if (idx == 2'd3) state_nxt = LAST;
            end
            LAST: state_nxt = FULL;
            FULL: begin
               if (slot_free) begin
                  state_nxt    = ISSUE;
                  idx_nxt      = 2'd0;
                  fetch_pc_nxt = fetch_pc + PC_STEP;
               end
            end
            default: state_nxt = ISSUE;
         endcase
      end
   end

   // Read data lags the strobe by one cycle, so ISSUE stores the word requested
   // in the previous cycle and LAST stores the final one.
   always_comb begin
      Mem_rd   = (state == ISSUE) && !rst;
      transfer = (state == FULL) && slot_free && !Jump;
      buf_we   = 1'b0;
      buf_idx  = 2'd0;
      if (!Jump) begin
         if (state == ISSUE && idx != 2'd0) begin
            buf_we  = 1'b1;
            buf_idx = idx - 2'd1;
         end else if (state == LAST) begin
            buf_we  = 1'b1;
            buf_idx = 2'(DEST);
         end
      end
   end

   instr_word_buf #(
      .UUID (UUID ^ 32'h1),
      .NAME (NAME)
   ) u_word_buf (
      .clk     (clk),
      .clear   (rst || Jump),
      .wr_en   (buf_we),
      .wr_idx  (buf_idx),
      .wr_data (Mem_data),
      .words   (buf_words)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         Op_code     <= '0;
         Arg_1       <= '0;
         Arg_2       <= '0;
         Dest        <= '0;
         Pc          <= '0;
         Instr_valid <= 1'b0;
      end else begin
         if (transfer) begin
            Op_code <= buf_words[OPCODE];
            Arg_1   <= buf_words[ARG1];
            Arg_2   <= buf_words[ARG2];
            Dest    <= buf_words[DEST];
            Pc      <= fetch_pc;
         end
         if (Jump) begin
            Instr_valid <= 1'b0;
         end else if (transfer) begin
            Instr_valid <= 1'b1;
         end else if (handshake) begin
            Instr_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage that sits directly upstream of `inp_addr_mux`. It reads 32-bit program memory one word per cycle and assembles each instruction from 4 consecutive words: Op_code, Arg_1, Arg_2, Dest. It presents the instruction to decode/operand selection with a valid/ready handshake. Op_code feeds the mux's `Op_code`, and Arg_1/Arg_2 feed `Inp_1`/`Inp_2` and the register-address paths. Jumps from execute redirect fetch and flush partial work.

## Interface
- UUID, 0, component identity (XOR-combined into children)
- NAME, "", instance name
- RESET_PC, 32'h0, fetch address after reset; bits [1:0] treated as 0
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- Mem_addr  out  32  program memory word address
- Mem_rd  out  1  read strobe
- Mem_data  in  32  read data; valid exactly 1 cycle after Mem_rd
- Op_code  out  32  instruction word 0
- Arg_1  out  32  instruction word 1
- Arg_2  out  32  instruction word 2
- Dest  out  32  instruction word 3
- Pc  out  32  word address of the presented instruction
- Instr_valid  out  1  output instruction valid
- Instr_ready  in  1  downstream accepts; handshake = Instr_valid & Instr_ready
- Jump  in  1  redirect request
- Jump_addr  in  32  redirect target; bits [1:0] forced to 0

## Operation
- Registers:
  - Fetch_pc (32), a staging buffer of 4x32, Idx (2 bits), state.
  - Output registers: Op_code/Arg_1/Arg_2/Dest/Pc/Instr_valid.
- FSM states:
  - ISSUE: Mem_rd=1, Mem_addr=Fetch_pc+Idx. If Idx>0, capture Mem_data into staging[Idx-1]. Idx increments. At Idx=3 go to LAST.
  - LAST: Mem_rd=0. Capture Mem_data into staging[3]. Go to FULL.
  - FULL: Mem_rd=0. Transfer when the output slot is free (!Instr_valid | Instr_ready). Transfer copies staging to the outputs, sets Pc=Fetch_pc and Instr_valid=1, sets Fetch_pc+=4, and goes to ISSUE with Idx=0.
- Instr_valid clears on a handshake unless a transfer happens in the same cycle.
- Outputs are stable while Instr_valid=1 and Instr_ready=0.
- Arithmetic: Fetch_pc and Mem_addr are 32-bit modulo 2^32. Fetch_pc+Idx carries naturally; 0xFFFFFFFC+4 wraps to 0.
- Jump (highest priority below rst), in any state:
  - Sets Fetch_pc=Jump_addr&~3, state=ISSUE, Idx=0.
  - Clears Instr_valid next cycle.
  - Discards staging. Read data in flight is ignored because ISSUE with Idx=0 does not capture.
  - A handshake coinciding with Jump still counts as accepted.
  - Jump blocks a FULL transfer in the same cycle.
- Reset (rst=1, any cycle including mid-fill or while FULL):
  - Next cycle: state=ISSUE, Idx=0, Fetch_pc=RESET_PC.
  - All outputs and staging reset to 0, Instr_valid=0.
  - Mem_rd is gated to 0 while rst=1.

## Timing
- Cycle 0 is the first cycle with rst=0. Reads issue in cycles 0–3 (addr RESET_PC+0..3).
- Data is captured at the end of cycles 1–4, FULL runs in cycle 5, and Instr_valid=1 in cycle 6.
- Steady state with Instr_ready=1: one instruction per 6 cycles.
- Backpressure: the engine parks in FULL with Mem_rd=0. In the cycle Instr_ready rises, both the handshake and the transfer occur. The next instruction is valid the following cycle.
- After Jump at cycle t: Mem_addr=target in cycle t+1, and the first instruction is valid at t+7.

## Structure
- Shared package holds:
  - WORDS_PER_INSTR=4
  - PC_STEP=4
  - state encoding ISSUE/LAST/FULL (2-bit)
  - output word index constants OPCODE=0, ARG1=1, ARG2=2, DEST=3
- One sub-module, `instr_word_buf`: 4x32 staging registers with indexed write enable, a clear input, and a parallel read.

## Test plan
- Reset, Instr_ready=1, mem[n]=n*0x11:
  - Mem_addr 0,1,2,3 in cycles 0–3.
  - Cycle 6: Instr_valid=1, Op_code=0, Arg_1=0x11, Arg_2=0x22, Dest=0x33, Pc=0.
  - Cycle 12: Pc=4, Op_code=0x44.
- Instr_ready=0 for 20 cycles after the first valid:
  - Outputs stay frozen and Mem_rd=0 after the second fill.
  - Raise Instr_ready at cycle t → Pc=4 instruction valid at t+1 with no re-read.
- Jump=1, Jump_addr=0x103 during ISSUE Idx=2:
  - Next cycle Mem_addr=0x100 and Instr_valid=0.
  - Next instruction has Pc=0x100 with words from 0x100–0x103, and no stale word appears.
- RESET_PC=0xFFFFFFFC: Mem_addr sequence FFFFFFFC..FFFFFFFF, then the next instruction fetches from 0x0 with Pc=0.
- rst pulsed for 1 cycle while FULL with Instr_valid=1:
  - Next cycle all outputs are 0 and Mem_rd=0 during rst.
  - Fetch restarts at RESET_PC, and the first valid appears 6 cycles after rst falls.
- Jump and handshake in the same cycle: the handshake counts as accepted, Instr_valid=0 next cycle, and there is no duplicate presentation of the accepted Pc.
